// File: rtl/cap_ecc_chk_pipe.sv
// Read-side SEC-DED checker/corrector: syndrome stage, decode/correct stage,
// plus sticky first-error capture and saturating SBE/DBE counters.
module cap_ecc_chk_pipe #(
    parameter int WIDTH     = 8,
    parameter int CODEWIDTH = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       inValid,
    input  logic [WIDTH+CODEWIDTH-1:0] eccDataIn,
    input  logic                       correctEn,
    input  logic                       errClr,
    output logic                       outValid,
    output logic [WIDTH-1:0]           dataOut,
    output logic                       sbeOut,
    output logic                       dbeOut,
    output logic                       errCapValid,
    output logic [CODEWIDTH-1:0]       errCapSyndrome,
    output logic                       errCapType,
    output logic [CNT_WIDTH-1:0]       sbeCount,
    output logic [CNT_WIDTH-1:0]       dbeCount
);

    localparam int SW   = CODEWIDTH - 1;
    localparam int NPOS = WIDTH + CODEWIDTH - 1;
    localparam logic [SW-1:0] NPOS_S = SW'(NPOS);

    // 1-based codeword position of data bit k (k-th non-power-of-2 slot)
    function automatic int data_pos(input int k);
        int n;
        int pos;
        n   = 0;
        pos = 0;
        for (int q = 1; q <= NPOS; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (n == k) pos = q;
                n++;
            end
        end
        return pos;
    endfunction

    // stage 1: syndrome and overall parity
    logic             v1_q, v1_d;
    logic             ce1_q, ce1_d;
    logic [WIDTH-1:0] data1_q, data1_d;
    logic [SW-1:0]    s1_q, s1_d;
    logic             p1_q, p1_d;
    logic [SW-1:0]    chk;

    always_comb begin
        chk = '0;
        for (int c = 0; c < SW; c++) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (((data_pos(k) >> c) & 1) == 1) begin
                    chk[c] = chk[c] ^ eccDataIn[k];
                end
            end
        end
    end

    always_comb begin
        v1_d    = inValid;
        ce1_d   = ce1_q;
        data1_d = data1_q;
        s1_d    = s1_q;
        p1_d    = p1_q;
        if (inValid) begin
            ce1_d   = correctEn;
            data1_d = eccDataIn[WIDTH-1:0];
            s1_d    = chk ^ eccDataIn[WIDTH +: SW];
            p1_d    = ^eccDataIn;
        end
    end

    // stage 2: decode, correct, register outputs
    logic                 v2_q, v2_d;
    logic [WIDTH-1:0]     data2_q, data2_d;
    logic                 sbe2_q, sbe2_d;
    logic                 dbe2_q, dbe2_d;
    logic [CODEWIDTH-1:0] syn2_q, syn2_d;
    logic                 s_pow2;
    logic                 s_in_rng;
    logic                 dec_sbe;
    logic                 dec_dbe;
    logic                 dec_fix;
    logic [WIDTH-1:0]     corr;

    always_comb begin
        s_pow2   = (s1_q & (s1_q - SW'(1))) == '0;
        s_in_rng = s1_q <= NPOS_S;
        dec_sbe  = p1_q & (s_pow2 | s_in_rng);
        dec_dbe  = (p1_q & ~s_pow2 & ~s_in_rng) | (~p1_q & (s1_q != '0));
        dec_fix  = p1_q & ~s_pow2 & s_in_rng & ce1_q;
        corr     = data1_q;
        for (int k = 0; k < WIDTH; k++) begin
            if (dec_fix && (data_pos(k) == int'(s1_q))) begin
                corr[k] = ~data1_q[k];
            end
        end
    end

    always_comb begin
        v2_d    = v1_q;
        data2_d = data2_q;
        sbe2_d  = 1'b0;
        dbe2_d  = 1'b0;
        syn2_d  = syn2_q;
        if (v1_q) begin
            data2_d = corr;
            sbe2_d  = dec_sbe;
            dbe2_d  = dec_dbe;
            syn2_d  = {p1_q, s1_q};
        end
    end

    // capture and counters follow the registered output flags
    logic                 cap_v_q, cap_v_d;
    logic [CODEWIDTH-1:0] cap_syn_q, cap_syn_d;
    logic                 cap_t_q, cap_t_d;
    logic [CNT_WIDTH-1:0] sbe_cnt_q, sbe_cnt_d;
    logic [CNT_WIDTH-1:0] dbe_cnt_q, dbe_cnt_d;
    logic                 err_ev;

    always_comb begin
        err_ev    = v2_q & (sbe2_q | dbe2_q);
        cap_v_d   = cap_v_q;
        cap_syn_d = cap_syn_q;
        cap_t_d   = cap_t_q;
        sbe_cnt_d = sbe_cnt_q;
        dbe_cnt_d = dbe_cnt_q;
        if (errClr) begin
            cap_v_d   = 1'b0;
            cap_syn_d = '0;
            cap_t_d   = 1'b0;
            sbe_cnt_d = '0;
            dbe_cnt_d = '0;
        end else begin
            if (err_ev && !cap_v_q) begin
                cap_v_d   = 1'b1;
                cap_syn_d = syn2_q;
                cap_t_d   = dbe2_q;
            end
            if (v2_q && sbe2_q && (sbe_cnt_q != {CNT_WIDTH{1'b1}})) begin
                sbe_cnt_d = sbe_cnt_q + CNT_WIDTH'(1);
            end
            if (v2_q && dbe2_q && (dbe_cnt_q != {CNT_WIDTH{1'b1}})) begin
                dbe_cnt_d = dbe_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q      <= 1'b0;
            ce1_q     <= 1'b0;
            data1_q   <= '0;
            s1_q      <= '0;
            p1_q      <= 1'b0;
            v2_q      <= 1'b0;
            data2_q   <= '0;
            sbe2_q    <= 1'b0;
            dbe2_q    <= 1'b0;
            syn2_q    <= '0;
            cap_v_q   <= 1'b0;
            cap_syn_q <= '0;
            cap_t_q   <= 1'b0;
            sbe_cnt_q <= '0;
            dbe_cnt_q <= '0;
        end else begin
            v1_q      <= v1_d;
            ce1_q     <= ce1_d;
            data1_q   <= data1_d;
            s1_q      <= s1_d;
            p1_q      <= p1_d;
            v2_q      <= v2_d;
            data2_q   <= data2_d;
            sbe2_q    <= sbe2_d;
            dbe2_q    <= dbe2_d;
            syn2_q    <= syn2_d;
            cap_v_q   <= cap_v_d;
            cap_syn_q <= cap_syn_d;
            cap_t_q   <= cap_t_d;
            sbe_cnt_q <= sbe_cnt_d;
            dbe_cnt_q <= dbe_cnt_d;
        end
    end

    assign outValid       = v2_q;
    assign dataOut        = data2_q;
    assign sbeOut         = sbe2_q;
    assign dbeOut         = dbe2_q;
    assign errCapValid    = cap_v_q;
    assign errCapSyndrome = cap_syn_q;
    assign errCapType     = cap_t_q;
    assign sbeCount       = sbe_cnt_q;
    assign dbeCount       = dbe_cnt_q;

endmodule
